// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding, tile configuration record and default widths for the systolic-array controller
package sa_pkg;
    localparam int SA_ADDR_WIDTH = 8;
    localparam int SA_M_WIDTH    = 8;

    typedef enum logic [1:0] {IDLE, PRELOAD, STREAM, FLUSH} sa_state_e;

    typedef struct packed {
        logic [SA_ADDR_WIDTH-1:0] w_offset;
        logic [SA_ADDR_WIDTH-1:0] in_offset;
        logic [SA_ADDR_WIDTH-1:0] out_offset;
        logic [SA_M_WIDTH-1:0]    m_dim;
    } data_config_s;
endpackage

// File: rtl/sa_controller_if.sv
// sa_controller_if: start/config request plus buffer strobes, addresses and status of one tile sequencer
//   master: drives start_i, cfg_i; observes everything else
//   slave : the controller side
interface sa_controller_if import sa_pkg::*; #(
    parameter int ADDR_WIDTH = SA_ADDR_WIDTH
) ();
    logic                  start_i;
    data_config_s          cfg_i;
    sa_state_e             state_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  w_rd_en_o;
    logic [ADDR_WIDTH-1:0] w_addr_o;
    logic                  pe_load_w_o;
    logic                  in_rd_en_o;
    logic [ADDR_WIDTH-1:0] in_addr_o;
    logic                  pe_en_o;
    logic                  out_wr_en_o;
    logic [ADDR_WIDTH-1:0] out_addr_o;
    logic [15:0]           perf_cycles_o;

    modport master (
        output start_i, cfg_i,
        input  state_o, busy_o, done_o, w_rd_en_o, w_addr_o, pe_load_w_o,
               in_rd_en_o, in_addr_o, pe_en_o, out_wr_en_o, out_addr_o, perf_cycles_o
    );
    modport slave (
        input  start_i, cfg_i,
        output state_o, busy_o, done_o, w_rd_en_o, w_addr_o, pe_load_w_o,
               in_rd_en_o, in_addr_o, pe_en_o, out_wr_en_o, out_addr_o, perf_cycles_o
    );
endinterface

// File: rtl/sa_addr_gen.sv
// sa_addr_gen: strobe counter producing addr = base + count (modulo 2^W)
//   clk, rst_n : clock, async active-low reset
//   base       : address offset
//   clear      : synchronous count clear
//   enable     : advance count after this cycle
//   addr, count: current address and number of enabled cycles since clear
module sa_addr_gen #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  base,
    input  logic          clear,
    input  logic          enable,
    output logic [W-1:0]  addr,
    output logic [CW-1:0] count
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (clear) count <= '0;
        else if (enable) count <= count + CW'(1);

    assign addr = base + W'(count);
endmodule

// File: rtl/sa_controller.sv
// sa_controller: per-tile IDLE->PRELOAD->STREAM->FLUSH sequencer driving systolic-array buffers and strobes
//   clk, rst_n : clock, async active-low reset
//   bus        : sa_controller_if.slave (start_i/cfg_i in; state, strobes, addresses, done, perf out)
//   Optional SA_CTRL_PERF_EN: builds a saturating busy-cycle counter on perf_cycles_o (else tied 0).
module sa_controller import sa_pkg::*; #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int ADDR_WIDTH = SA_ADDR_WIDTH,
    parameter int M_WIDTH    = SA_M_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    sa_controller_if.slave  bus
);
    localparam int OUT_LAT = ROWS + COLS;

    sa_state_e             state;
    data_config_s          cfg_q;
    logic                  done, w_en, pl, in_en, pe;
    logic [OUT_LAT-1:0]    sr;
    logic [ADDR_WIDTH-1:0] w_addr, in_addr, out_addr;
    logic [M_WIDTH-1:0]    w_cnt, in_cnt, out_cnt, last;
    logic                  accept;

    assign accept = state == IDLE && bus.start_i;
    assign last   = M_WIDTH'(cfg_q.m_dim - 1'b1);

    sa_addr_gen #(.W(ADDR_WIDTH), .CW(M_WIDTH)) u_w (
        .clk(clk), .rst_n(rst_n), .base(ADDR_WIDTH'(cfg_q.w_offset)), .clear(accept),
        .enable(w_en), .addr(w_addr), .count(w_cnt));
    sa_addr_gen #(.W(ADDR_WIDTH), .CW(M_WIDTH)) u_in (
        .clk(clk), .rst_n(rst_n), .base(ADDR_WIDTH'(cfg_q.in_offset)), .clear(accept),
        .enable(in_en), .addr(in_addr), .count(in_cnt));
    sa_addr_gen #(.W(ADDR_WIDTH), .CW(M_WIDTH)) u_out (
        .clk(clk), .rst_n(rst_n), .base(ADDR_WIDTH'(cfg_q.out_offset)), .clear(accept),
        .enable(sr[OUT_LAT-1]), .addr(out_addr), .count(out_cnt));

    // The last output write always lands in the final FLUSH cycle, so the write count ends FLUSH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cfg_q <= '0;
            done  <= 1'b0;
            w_en  <= 1'b0;
            pl    <= 1'b0;
            in_en <= 1'b0;
            pe    <= 1'b0;
            sr    <= '0;
        end else begin
            done <= 1'b0;
            pl   <= w_en;
            pe   <= in_en;
            sr   <= {sr[OUT_LAT-2:0], in_en};
            case (state)
                IDLE: if (bus.start_i) begin
                    cfg_q <= bus.cfg_i;
                    if (bus.cfg_i.m_dim != '0) begin
                        state <= PRELOAD;
                        w_en  <= 1'b1;
                    end else done <= 1'b1;
                end
                PRELOAD: if (w_cnt == M_WIDTH'(ROWS - 1)) begin
                    state <= STREAM;
                    w_en  <= 1'b0;
                    in_en <= 1'b1;
                end
                STREAM: if (in_cnt == last) begin
                    state <= FLUSH;
                    in_en <= 1'b0;
                end
                FLUSH: if (sr[OUT_LAT-1] && out_cnt == last) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.state_o     = state;
    assign bus.busy_o      = state != IDLE;
    assign bus.done_o      = done;
    assign bus.w_rd_en_o   = w_en;
    assign bus.w_addr_o    = w_en ? w_addr : '0;
    assign bus.pe_load_w_o = pl;
    assign bus.in_rd_en_o  = in_en;
    assign bus.in_addr_o   = in_en ? in_addr : '0;
    assign bus.pe_en_o     = pe;
    assign bus.out_wr_en_o = sr[OUT_LAT-1];
    assign bus.out_addr_o  = sr[OUT_LAT-1] ? out_addr : '0;

`ifdef SA_CTRL_PERF_EN
    logic [15:0] perf;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) perf <= '0;
        else if (accept && bus.cfg_i.m_dim != '0) perf <= '0;
        else if (state != IDLE && perf != 16'hFFFF) perf <= perf + 16'd1;
    assign bus.perf_cycles_o = perf;
`else
    assign bus.perf_cycles_o = '0;
`endif
endmodule
